// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and its six BCD digit counters.
// The counter/button side drives the master modport; the controller uses slave.
interface stopwatch_ctrl_if;
  logic        StartStop;
  logic        Clear;
  logic [23:0] Digitos;
  logic [5:0]  Enables;
  logic        ClearCount;
  logic        Running;
  logic        Paused;
  logic        Overflow;

  modport master (
    output StartStop, Clear, Digitos,
    input  Enables, ClearCount, Running, Paused, Overflow
  );

  modport slave (
    input  StartStop, Clear, Digitos,
    output Enables, ClearCount, Running, Paused, Overflow
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for a MM:SS.cc stopwatch: button edge detect,
// 100 Hz prescaler and the carry-enable chain across six BCD digit counters.
module stopwatch_ctrl #(
  parameter int PRESCALE = 500000,
  parameter bit WRAP     = 1'b1
) (
  input logic             Clock,
  input logic             Reset,
  stopwatch_ctrl_if.slave bus
);

  localparam int              PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);
  localparam logic [23:0]     FULL = 24'h595999;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, HOLD} state_t;

  state_t        state, next_state;
  logic          ss_prev_p1, clr_prev_p1;
  logic [PW-1:0] presc_p1;
  logic          tick_p1, clear_p1, ovf_p1;
  logic          ss_press, clr_press, clr_accept, tick, full;
  logic [5:0]    carry;

  // Digit i carries into digit i+1 only at its own maximum; corrupt values never carry.
  function automatic logic at_max(input logic [23:0] dig, input int i);
    logic [3:0] d;
    logic [3:0] mx;
    d  = dig[4*i +: 4];
    mx = (i == 3 || i == 5) ? 4'd5 : 4'd9;
    return d == mx;
  endfunction

  assign ss_press   = bus.StartStop & ~ss_prev_p1;
  assign clr_press  = bus.Clear & ~clr_prev_p1;
  assign clr_accept = clr_press & (state != RUN);
  assign tick       = tick_p1 & (state == RUN);
  assign full       = tick & (bus.Digitos == FULL);

  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (!clr_press && ss_press) next_state = RUN;
      RUN: begin
        if (full && !WRAP)  next_state = HOLD;
        else if (ss_press)  next_state = PAUSE;
      end
      PAUSE: begin
        if (clr_press)      next_state = IDLE;
        else if (ss_press)  next_state = RUN;
      end
      HOLD:  if (clr_press) next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  // Stage p1: button history, prescaler phase, tick, clear and overflow pulses.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ss_prev_p1  <= 1'b1;
      clr_prev_p1 <= 1'b1;
      presc_p1    <= '0;
      tick_p1     <= 1'b0;
      clear_p1    <= 1'b1;
      ovf_p1      <= 1'b0;
    end else begin
      ss_prev_p1  <= bus.StartStop;
      clr_prev_p1 <= bus.Clear;
      clear_p1    <= clr_accept;
      ovf_p1      <= WRAP && full;
      tick_p1     <= (state == RUN) && (presc_p1 == LAST);
      if (clr_accept)
        presc_p1 <= '0;
      else if (state == RUN)
        presc_p1 <= (presc_p1 == LAST) ? '0 : presc_p1 + PW'(1);
    end
  end

  always_comb begin
    carry[0] = tick;
    for (int i = 1; i < 6; i++)
      carry[i] = carry[i-1] & at_max(bus.Digitos, i - 1);
    bus.Enables = (full && !WRAP) ? 6'b0 : carry;
    bus.Running = (state == RUN);
    bus.Paused  = (state == PAUSE);
  end

  assign bus.ClearCount = clear_p1;
  assign bus.Overflow   = ovf_p1;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Random-stimulus scoreboard bench: a WRAP=1 and a WRAP=0 controller share inputs
// and are compared every cycle against a behavioural stopwatch model.
module tb_stopwatch_ctrl;
  localparam int P      = 4;
  localparam int NCYC   = 4000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_HOLD = 3;
  localparam int MX[6]  = '{9, 9, 9, 5, 9, 5};

  typedef struct packed {
    logic [5:0] en;
    logic       cc;
    logic       run;
    logic       pau;
    logic       ovf;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ss, clr;
  logic [23:0] dig;

  int passed = 0;
  int total  = 0;

  exp_t q_w[$];
  exp_t q_h[$];

  int  mode[2];
  int  phase[2];
  bit  tick[2];
  bit  ovf[2];
  bit  cc[2];
  bit  ss_prev, clr_prev;

  always #5 Clock = ~Clock;

  stopwatch_ctrl_if bus_w ();
  stopwatch_ctrl_if bus_h ();

  assign bus_w.StartStop = ss;
  assign bus_w.Clear     = clr;
  assign bus_w.Digitos   = dig;
  assign bus_h.StartStop = ss;
  assign bus_h.Clear     = clr;
  assign bus_h.Digitos   = dig;

  stopwatch_ctrl #(.PRESCALE(P), .WRAP(1'b1)) dut_w (.Clock(Clock), .Reset(Reset), .bus(bus_w.slave));
  stopwatch_ctrl #(.PRESCALE(P), .WRAP(1'b0)) dut_h (.Clock(Clock), .Reset(Reset), .bus(bus_h.slave));

  // Enables form a run of ones: one for the tick plus one per trailing digit at its maximum.
  function automatic logic [5:0] chain(input logic [23:0] d);
    int n;
    n = 0;
    while (n < 5 && int'(d[4*n +: 4]) == MX[n]) n++;
    return 6'((1 << (n + 1)) - 1);
  endfunction

  function automatic logic [23:0] pick();
    case ($urandom_range(0, 10))
      0:       return 24'h000000;
      1:       return 24'h000009;
      2:       return 24'h000099;
      3:       return 24'h000999;
      4:       return 24'h005999;
      5:       return 24'h095999;
      6, 7:    return 24'h595999;
      8:       return 24'h5959A9;
      9:       return 24'h595989;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic step_model(input logic rst_n, input logic s, input logic c, input logic [23:0] d);
    bit sp, cp, wr, full, acc, wrapped;
    int nm;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mode[k] = M_IDLE; phase[k] = 0; tick[k] = 0; ovf[k] = 0; cc[k] = 1;
      end
      ss_prev = 1; clr_prev = 1;
      return;
    end
    sp = s && !ss_prev;
    cp = c && !clr_prev;
    for (int k = 0; k < 2; k++) begin
      wr      = (k == 0);
      full    = tick[k] && (d == 24'h595999);
      wrapped = 0;
      nm      = mode[k];
      if (mode[k] == M_RUN) begin
        phase[k]++;
        if (phase[k] == P) begin phase[k] = 0; wrapped = 1; end
      end
      acc = cp && (mode[k] != M_RUN);
      case (mode[k])
        M_IDLE:  if (!cp && sp) nm = M_RUN;
        M_RUN:   if (full && !wr) nm = M_HOLD; else if (sp) nm = M_PAUSE;
        M_PAUSE: if (cp) nm = M_IDLE; else if (sp) nm = M_RUN;
        default: if (cp) nm = M_IDLE;
      endcase
      if (acc) phase[k] = 0;
      ovf[k]  = full && wr;
      cc[k]   = acc;
      tick[k] = wrapped && (nm == M_RUN);
      mode[k] = nm;
    end
    ss_prev  = s;
    clr_prev = c;
  endtask

  function automatic exp_t expect_out(input int k, input logic [23:0] d);
    exp_t e;
    e.en  = tick[k] ? chain(d) : 6'b0;
    if (k == 1 && tick[k] && d == 24'h595999) e.en = 6'b0;
    e.cc  = cc[k];
    e.run = (mode[k] == M_RUN);
    e.pau = (mode[k] == M_PAUSE);
    e.ovf = ovf[k];
    return e;
  endfunction

  task automatic cmp(input string name, input logic [5:0] got, input logic [5:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
  endtask

  task automatic check_all(input string tag, input exp_t e, input logic [5:0] en,
                           input logic cc_o, input logic run, input logic pau, input logic ov);
    cmp({tag, ".Enables"},    en,           e.en);
    cmp({tag, ".ClearCount"}, 6'(cc_o),     6'(e.cc));
    cmp({tag, ".Running"},    6'(run),      6'(e.run));
    cmp({tag, ".Paused"},     6'(pau),      6'(e.pau));
    cmp({tag, ".Overflow"},   6'(ov),       6'(e.ovf));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      if (q_w.size() > 0) begin
        e = q_w.pop_front();
        check_all("wrap", e, bus_w.Enables, bus_w.ClearCount, bus_w.Running, bus_w.Paused, bus_w.Overflow);
      end
      if (q_h.size() > 0) begin
        e = q_h.pop_front();
        check_all("hold", e, bus_h.Enables, bus_h.ClearCount, bus_h.Running, bus_h.Paused, bus_h.Overflow);
      end
    end
  end

  initial begin : stimulus
    logic rst_e, ss_e, clr_e;
    logic [23:0] dig_e;
    Reset = 1'b0; ss = 1'b1; clr = 1'b0; dig = 24'h0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      rst_e = Reset; ss_e = ss; clr_e = clr; dig_e = dig;
      @(posedge Clock);
      #1;
      step_model(rst_e, ss_e, clr_e, dig_e);
      if (cyc < 2)                              Reset = 1'b0;
      else if ($urandom_range(0, 599) == 0)     Reset = 1'b0;
      else                                      Reset = 1'b1;
      if (cyc >= 8) begin
        if ($urandom_range(0, 7) == 0) ss  = ~ss;
        if ($urandom_range(0, 7) == 0) clr = ~clr;
        if ($urandom_range(0, 24) == 0 && !ss && !clr) begin ss = 1'b1; clr = 1'b1; end
      end
      dig = pick();
      q_w.push_back(expect_out(0, dig));
      q_h.push_back(expect_out(1, dig));
    end
    repeat (3) @(negedge Clock);
    cmp("drain", 6'(q_w.size() + q_h.size()), 6'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
